axis_video_checker: RTL and testbench

//  AXI4-Stream video sink for 720p test-pattern bring-up. Accepts 24-bit pixels

---
 rtl/axis_video_checker.sv | 211 +++++++++++++++++++++
 tb/tb_axis_video_checker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_video_checker.sv
// -----------------------------------------------------------------------------
// axis_video_checker
//   AXI4-Stream video sink for 720p test-pattern bring-up. It accepts 24-bit
//   pixels marked with start-of-frame (i_start) and end-of-line (i_last). It
//   checks the frame framing and the expected 3-bar colour pattern, and reports
//   frame completion and sticky error status.
//
//   Optional feature macro: VCHK_BACKPRESSURE_EN
//     Defined     : o_ready is driven by a 16-bit LFSR (about 75% duty) so the
//                   source is forced to stall.
//     Not defined : o_ready is held at 1 from the first cycle after reset.
//
// Ports
//   clk            clock
//   resetn         synchronous reset, active-low
//   i_color[23:0]  pixel data (8/8/8)
//   i_valid        pixel valid
//   i_start        start of frame (first pixel of a frame only)
//   i_last         end of line (pixel x == H_ACTIVE-1)
//   o_ready        sink ready
//   i_clear        clears the sticky error flags and o_err_count
//   o_frame_done   1-cycle pulse per complete frame
//   o_frame_count  completed frames (wraps)
//   o_err_sof      sticky: misplaced or missing i_start
//   o_err_eol      sticky: misplaced or missing i_last
//   o_err_pixel    sticky: colour mismatch
//   o_err_count    beats with at least one error (saturates)
//
// state    | meaning
// ---------+----------------------------------------------------------
// WAIT_SOF | idle; beats without i_start are dropped as SOF errors
// RECV     | inside a frame; (r_x, r_y) is the next expected pixel
// -----------------------------------------------------------------------------
module axis_video_checker #(
    parameter int          H_ACTIVE = 1280,
    parameter int          V_ACTIVE = 720,
    parameter int          BAR1_END = 427,
    parameter int          BAR2_END = 853,
    parameter logic [23:0] COLOR0   = 24'h0000ff,
    parameter logic [23:0] COLOR1   = 24'h00ff00,
    parameter logic [23:0] COLOR2   = 24'hff0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [23:0] i_color,
    input  logic        i_valid,
    input  logic        i_start,
    input  logic        i_last,
    output logic        o_ready,
    input  logic        i_clear,
    output logic        o_frame_done,
    output logic [15:0] o_frame_count,
    output logic        o_err_sof,
    output logic        o_err_eol,
    output logic        o_err_pixel,
    output logic [15:0] o_err_count
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [XW-1:0] X_BAR1 = XW'(BAR1_END);
    localparam logic [XW-1:0] X_BAR2 = XW'(BAR2_END);

    typedef enum logic {
        S_WAIT_SOF = 1'b0,
        S_RECV     = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [XW-1:0]  r_x;
    logic [YW-1:0]  r_y;
    logic [XW-1:0]  w_x_nxt;
    logic [YW-1:0]  w_y_nxt;
    logic [XW-1:0]  w_px;
    logic [YW-1:0]  w_py;
    logic           w_x_end;
    logic [23:0]    w_exp_color;
    logic           w_beat;
    logic           w_frame_end;
    logic           w_e_sof;
    logic           w_e_eol;
    logic           w_e_pix;
    logic           r_run;
    logic           r_frame_done;
    logic [15:0]    r_frame_count;
    logic           r_err_sof;
    logic           r_err_eol;
    logic           r_err_pixel;
    logic [15:0]    r_err_count;

`ifdef VCHK_BACKPRESSURE_EN
    // Fibonacci LFSR, taps 16,14,13,11; ready when either of the two low bits is set.
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    assign o_ready = r_run & (r_lfsr[0] | r_lfsr[1]);
`else
    assign o_ready = r_run;
`endif

    assign w_beat = i_valid & o_ready;

    // A beat that carries i_start is always taken as pixel (0,0), which also
    // resynchronises when i_start arrives in the middle of a frame.
    assign w_px    = i_start ? '0 : r_x;
    assign w_py    = i_start ? '0 : r_y;
    assign w_x_end = (w_px == X_LAST);

    always_comb begin
        if (w_px < X_BAR1) begin
            w_exp_color = COLOR0;
        end else if (w_px < X_BAR2) begin
            w_exp_color = COLOR1;
        end else begin
            w_exp_color = COLOR2;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_frame_end = 1'b0;
        w_e_sof     = 1'b0;
        w_e_eol     = 1'b0;
        w_e_pix     = 1'b0;
        if (w_beat) begin
            if ((r_state == S_WAIT_SOF) && !i_start) begin
                w_e_sof = 1'b1;
            end else begin
                w_e_sof = (r_state == S_RECV) && i_start;
                w_e_eol = (i_last != w_x_end);
                w_e_pix = (i_color != w_exp_color);
                // The line ends on i_last or at the last column, whichever comes first.
                if (i_last || w_x_end) begin
                    w_x_nxt = '0;
                    if (w_py == Y_LAST) begin
                        w_frame_end = 1'b1;
                        w_y_nxt     = '0;
                        w_state_nxt = S_WAIT_SOF;
                    end else begin
                        w_y_nxt     = w_py + YW'(1);
                        w_state_nxt = S_RECV;
                    end
                end else begin
                    w_x_nxt     = w_px + XW'(1);
                    w_y_nxt     = w_py;
                    w_state_nxt = S_RECV;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= S_WAIT_SOF;
            r_x           <= '0;
            r_y           <= '0;
            r_run         <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_err_sof     <= 1'b0;
            r_err_eol     <= 1'b0;
            r_err_pixel   <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_run        <= 1'b1;
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (i_clear) begin
                r_err_sof   <= 1'b0;
                r_err_eol   <= 1'b0;
                r_err_pixel <= 1'b0;
                r_err_count <= '0;
            end else if (w_e_sof || w_e_eol || w_e_pix) begin
                r_err_sof   <= r_err_sof   | w_e_sof;
                r_err_eol   <= r_err_eol   | w_e_eol;
                r_err_pixel <= r_err_pixel | w_e_pix;
                if (r_err_count != 16'hFFFF) begin
                    r_err_count <= r_err_count + 16'd1;
                end
            end
        end
    end

    assign o_frame_done  = r_frame_done;
    assign o_frame_count = r_frame_count;
    assign o_err_sof     = r_err_sof;
    assign o_err_eol     = r_err_eol;
    assign o_err_pixel   = r_err_pixel;
    assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_axis_video_checker.sv
// -----------------------------------------------------------------------------
// tb_axis_video_checker
//   Directed bench for axis_video_checker on a reduced 12x4 raster with bars
//   at x<4, x<8 and the rest. Inputs change on the falling edge and outputs are
//   sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_axis_video_checker;

    localparam int          H  = 12;
    localparam int          V  = 4;
    localparam int          B1 = 4;
    localparam int          B2 = 8;
    localparam logic [23:0] C0 = 24'h0000ff;
    localparam logic [23:0] C1 = 24'h00ff00;
    localparam logic [23:0] C2 = 24'hff0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [23:0] i_color;
    logic        i_valid;
    logic        i_start;
    logic        i_last;
    logic        o_ready;
    logic        i_clear;
    logic        o_frame_done;
    logic [15:0] o_frame_count;
    logic        o_err_sof;
    logic        o_err_eol;
    logic        o_err_pixel;
    logic [15:0] o_err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int done_base;

    always #5 clk = ~clk;

    axis_video_checker #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .BAR1_END (B1),
        .BAR2_END (B2),
        .COLOR0   (C0),
        .COLOR1   (C1),
        .COLOR2   (C2)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .i_color       (i_color),
        .i_valid       (i_valid),
        .i_start       (i_start),
        .i_last        (i_last),
        .o_ready       (o_ready),
        .i_clear       (i_clear),
        .o_frame_done  (o_frame_done),
        .o_frame_count (o_frame_count),
        .o_err_sof     (o_err_sof),
        .o_err_eol     (o_err_eol),
        .o_err_pixel   (o_err_pixel),
        .o_err_count   (o_err_count)
    );

    always @(negedge clk) begin
        if (o_frame_done === 1'b1) n_done++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] bar(input int x);
        if (x < B1) return C0;
        if (x < B2) return C1;
        return C2;
    endfunction

    // Presents one pixel and returns at the falling edge after it was accepted.
    task automatic send(input logic [23:0] c, input logic s, input logic l);
        int guard = 0;
        i_color = c;
        i_start = s;
        i_last  = l;
        i_valid = 1'b1;
        while (o_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        if (guard >= 100) chk("ready_timeout", guard, 0);
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        i_start = 1'b0;
        i_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // bad_*: pixel replaced by C0; early_*: i_last asserted early;
    // miss_y: i_last omitted at the last column; stop_y: abandon at that line.
    task automatic frame(input int bad_x, input int bad_y, input int early_x,
                         input int early_y, input int miss_y, input int stop_y);
        for (int y = 0; y < V; y++) begin
            if (y == stop_y) begin
                i_valid = 1'b0;
                return;
            end
            for (int x = 0; x < H; x++) begin
                logic l;
                logic [23:0] c;
                l = ((x == H - 1) && (y != miss_y)) || ((x == early_x) && (y == early_y));
                c = ((x == bad_x) && (y == bad_y)) ? C0 : bar(x);
                send(c, (x == 0) && (y == 0), l);
                if (l) break;
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic clear();
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
    endtask

    initial begin
        resetn  = 1'b0;
        i_color = '0;
        i_valid = 1'b0;
        i_start = 1'b0;
        i_last  = 1'b0;
        i_clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", o_ready, 0);
        chk("rst_done", o_frame_done, 0);
        chk("rst_fcount", o_frame_count, 0);
        chk("rst_err_flags", {o_err_sof, o_err_eol, o_err_pixel}, 0);
        chk("rst_ecount", o_err_count, 0);
        resetn = 1'b1;
        @(negedge clk);
`ifndef VCHK_BACKPRESSURE_EN
        chk("ready_after_rst", o_ready, 1);
`endif

        // Two clean frames
        frame(-1, -1, -1, -1, -1, -1);
        chk("done_pulse_hi", o_frame_done, 1);
        idle(1);
        chk("done_pulse_lo", o_frame_done, 0);
        frame(-1, -1, -1, -1, -1, -1);
        idle(2);
        chk("clean_done_pulses", n_done, 2);
        chk("clean_fcount", o_frame_count, 2);
        chk("clean_err_flags", {o_err_sof, o_err_eol, o_err_pixel}, 0);
        chk("clean_ecount", o_err_count, 0);

        // Bar-1 colour placed in bar 2
        frame(5, 1, -1, -1, -1, -1);
        idle(2);
        chk("pix_err", o_err_pixel, 1);
        chk("pix_ecount", o_err_count, 1);
        chk("pix_other_flags", {o_err_sof, o_err_eol}, 0);
        chk("pix_fcount", o_frame_count, 3);
        clear();
        chk("clear_flags", {o_err_sof, o_err_eol, o_err_pixel}, 0);
        chk("clear_ecount", o_err_count, 0);
        chk("clear_keeps_fcount", o_frame_count, 3);

        // Early i_last on line 1; next line must restart at x=0
        frame(-1, -1, 6, 1, -1, -1);
        idle(2);
        chk("early_eol_err", o_err_eol, 1);
        chk("early_eol_no_pix", o_err_pixel, 0);
        chk("early_eol_ecount", o_err_count, 1);
        chk("early_eol_fcount", o_frame_count, 4);
        chk("early_eol_done", n_done, 4);
        clear();

        // Missing i_last on line 2
        frame(-1, -1, -1, -1, 2, -1);
        idle(2);
        chk("miss_eol_err", o_err_eol, 1);
        chk("miss_eol_no_pix", o_err_pixel, 0);
        chk("miss_eol_ecount", o_err_count, 1);
        chk("miss_eol_fcount", o_frame_count, 5);
        clear();

        // Reset, then 10 beats without i_start, then a clean frame
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst2_fcount", o_frame_count, 0);
        done_base = n_done;
        for (int i = 0; i < 10; i++) send(C0, 1'b0, 1'b0);
        i_valid = 1'b0;
        chk("nosof_err", o_err_sof, 1);
        chk("nosof_ecount", o_err_count, 10);
        frame(-1, -1, -1, -1, -1, -1);
        idle(2);
        chk("nosof_fcount", o_frame_count, 1);
        chk("nosof_ecount_after", o_err_count, 10);
        chk("nosof_done", n_done - done_base, 1);
        clear();

        // i_start in the middle of a frame (line 2)
        done_base = n_done;
        frame(-1, -1, -1, -1, -1, 2);
        frame(-1, -1, -1, -1, -1, -1);
        idle(2);
        chk("midsof_err", o_err_sof, 1);
        chk("midsof_other_flags", {o_err_eol, o_err_pixel}, 0);
        chk("midsof_ecount", o_err_count, 1);
        chk("midsof_fcount", o_frame_count, 2);
        chk("midsof_done", n_done - done_base, 1);
        clear();

        // Clear coinciding with an erroneous beat
        i_clear = 1'b1;
        send(C0, 1'b0, 1'b0);
        i_clear = 1'b0;
        i_valid = 1'b0;
        chk("clr_vs_err_ecount", o_err_count, 0);
        chk("clr_vs_err_flag", o_err_sof, 0);
        send(C0, 1'b0, 1'b0);
        i_valid = 1'b0;
        chk("err_latency_ecount", o_err_count, 1);
        chk("err_latency_flag", o_err_sof, 1);

`ifdef VCHK_BACKPRESSURE_EN
        begin
            int n_rdy = 0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (o_ready === 1'b1) n_rdy++;
            end
            chk("ready_duty", (n_rdy >= 700) && (n_rdy <= 800), 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
